// File: rtl/afifo_wptr_full.sv
// Write-side pointer and status controller of the asynchronous FIFO (wclk domain).
// Keeps the binary write counter and publishes its Gray form, plus full, almost-full, fill level and overflow.
module afifo_wptr_full #(
   parameter int ADDRSIZE     = 4,
   parameter int AFULL_THRESH = 14
) (
   input  logic                wclk,
   input  logic                wrst,
   input  logic                winc,
   input  logic                woverflow_clr,
   input  logic [ADDRSIZE:0]   rptr_wclk,
   output logic                wen,
   output logic [ADDRSIZE-1:0] waddr,
   output logic [ADDRSIZE:0]   wptr,
   output logic                wfull,
   output logic                walmost_full,
   output logic [ADDRSIZE:0]   wlevel,
   output logic                woverflow
);

   localparam logic [ADDRSIZE:0] AFULL_L = (ADDRSIZE+1)'(AFULL_THRESH);

   logic [ADDRSIZE:0] wbin_reg;
   logic [ADDRSIZE:0] wbin_next;
   logic [ADDRSIZE:0] wgray_next;
   logic [ADDRSIZE:0] wptr_reg;
   logic [ADDRSIZE:0] wlevel_reg;
   logic [ADDRSIZE:0] level_next;
   logic [ADDRSIZE:0] rbin;
   logic              wfull_reg;
   logic              wfull_next;
   logic              walmost_full_reg;
   logic              woverflow_reg;
   logic              woverflow_next;

   // Each binary bit is the XOR of all Gray bits at and above it.
   genvar gi;
   generate
      for (gi = 0; gi <= ADDRSIZE; gi++) begin : g_gray2bin
         assign rbin[gi] = ^rptr_wclk[ADDRSIZE:gi];
      end
   endgenerate

   // Reset also gates the RAM strobe so nothing is written while wrst is high.
   assign wen        = winc & ~wfull_reg & ~wrst;
   assign wbin_next  = wbin_reg + {{ADDRSIZE{1'b0}}, wen};
   assign wgray_next = (wbin_next >> 1) ^ wbin_next;
   assign wfull_next = (wgray_next == {~rptr_wclk[ADDRSIZE:ADDRSIZE-1], rptr_wclk[ADDRSIZE-2:0]});
   assign level_next = wbin_next - rbin;

   always_comb begin
      woverflow_next = woverflow_reg;
      if (winc & wfull_reg)
         woverflow_next = 1'b1;
      else if (woverflow_clr)
         woverflow_next = 1'b0;
   end

   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         wbin_reg         <= '0;
         wptr_reg         <= '0;
         wfull_reg        <= 1'b0;
         walmost_full_reg <= 1'b0;
         wlevel_reg       <= '0;
         woverflow_reg    <= 1'b0;
      end else begin
         wbin_reg         <= wbin_next;
         wptr_reg         <= wgray_next;
         wfull_reg        <= wfull_next;
         walmost_full_reg <= (level_next >= AFULL_L);
         wlevel_reg       <= level_next;
         woverflow_reg    <= woverflow_next;
      end
   end

   assign waddr        = wbin_reg[ADDRSIZE-1:0];
   assign wptr         = wptr_reg;
   assign wfull        = wfull_reg;
   assign walmost_full = walmost_full_reg;
   assign wlevel       = wlevel_reg;
   assign woverflow    = woverflow_reg;

endmodule

// File: tb/tb_afifo_wptr_full.sv
// Bench for afifo_wptr_full: expectations are pushed to a queue as stimulus is applied
// and popped after the clock edge that should produce them.
module tb_afifo_wptr_full;

   localparam int A = 4;

   logic         wclk = 1'b0;
   logic         wrst = 1'b1;
   logic         winc = 1'b0;
   logic         woverflow_clr = 1'b0;
   logic [A:0]   rptr_wclk = '0;
   logic         wen;
   logic [A-1:0] waddr;
   logic [A:0]   wptr;
   logic         wfull;
   logic         walmost_full;
   logic [A:0]   wlevel;
   logic         woverflow;

   afifo_wptr_full #(.ADDRSIZE(A), .AFULL_THRESH(14)) dut (
      .wclk(wclk), .wrst(wrst), .winc(winc), .woverflow_clr(woverflow_clr),
      .rptr_wclk(rptr_wclk), .wen(wen), .waddr(waddr), .wptr(wptr),
      .wfull(wfull), .walmost_full(walmost_full), .wlevel(wlevel), .woverflow(woverflow)
   );

   always #5 wclk = ~wclk;

   typedef struct {
      logic [A:0]   wptr;
      logic [A-1:0] waddr;
      logic         wfull;
      logic         waf;
      logic [A:0]   wlevel;
      logic         wovf;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int checks = 0;
   int failures = 0;

   logic [A:0] m_wbin;
   logic       m_full;
   logic       m_ovf;
   logic       m_wen;

   function automatic logic [A:0] gray(input logic [A:0] b);
      return (b >> 1) ^ b;
   endfunction

   function automatic logic [A:0] g2b(input logic [A:0] g);
      logic [A:0] b;
      b[A] = g[A];
      for (int i = A - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   task automatic model_reset();
      m_wbin = '0;
      m_full = 1'b0;
      m_ovf  = 1'b0;
      m_wen  = 1'b0;
   endtask

   // Drive one cycle of inputs and push what the next edge should yield.
   task automatic set_in(input logic inc, input logic clr, input logic [A:0] rp);
      logic [A:0] nb, g, lvl;
      exp_t x;
      winc = inc;
      woverflow_clr = clr;
      rptr_wclk = rp;
      m_wen = inc & ~m_full;
      nb  = m_wbin + {{A{1'b0}}, m_wen};
      g   = gray(nb);
      lvl = nb - g2b(rp);
      x.wptr   = g;
      x.waddr  = nb[A-1:0];
      x.wfull  = (g == {~rp[A:A-1], rp[A-2:0]});
      x.wlevel = lvl;
      x.waf    = (lvl >= 5'd14);
      x.wovf   = (inc & m_full) ? 1'b1 : (clr ? 1'b0 : m_ovf);
      sb.push_back(x);
      m_wbin = nb;
      m_full = x.wfull;
      m_ovf  = x.wovf;
   endtask

   task automatic tick();
      @(posedge wclk);
      #1;
      if (sb.size() == 0) begin
         failures++;
         $display("FAIL scoreboard_empty got=0 entries required>=1");
         e = '{default: '0};
      end else begin
         e = sb.pop_front();
      end
   endtask

   task automatic test_reset();
      wrst = 1'b1;
      winc = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge wclk);
         #1;
         checks++;
         if ({wptr, waddr, wfull, walmost_full, wlevel, woverflow, wen} !== '0) begin
            failures++;
            $display("FAIL reset_outputs cyc=%0d got wptr=%b waddr=%0d wfull=%b wlevel=%0d wovf=%b wen=%b required all 0",
                     c, wptr, waddr, wfull, wlevel, woverflow, wen);
         end
      end
      winc = 1'b0;
      wrst = 1'b0;
      model_reset();
      $display("test_reset done");
   endtask

   task automatic test_fill();
      for (int i = 0; i < 16; i++) begin
         set_in(1'b1, 1'b0, '0);
         #1;
         checks++;
         if (waddr !== 4'(i) || wen !== 1'b1) begin
            failures++;
            $display("FAIL fill_waddr i=%0d got waddr=%0d wen=%b required waddr=%0d wen=1", i, waddr, wen, i);
         end
         tick();
         checks++;
         if (wptr !== e.wptr || wlevel !== e.wlevel || walmost_full !== e.waf || wfull !== e.wfull) begin
            failures++;
            $display("FAIL fill_step i=%0d got wptr=%b lvl=%0d af=%b full=%b required wptr=%b lvl=%0d af=%b full=%b",
                     i, wptr, wlevel, walmost_full, wfull, e.wptr, e.wlevel, e.waf, e.wfull);
         end
         if (i == 12 || i == 13) begin
            checks++;
            if (walmost_full !== (i == 13)) begin
               failures++;
               $display("FAIL fill_afull edge=%0d got=%b required=%b", i + 1, walmost_full, (i == 13));
            end
         end
         $display("fill write %0d wptr=%b wlevel=%0d", i + 1, wptr, wlevel);
      end
      checks++;
      if (wfull !== 1'b1 || wlevel !== 5'd16 || wptr !== 5'b11000) begin
         failures++;
         $display("FAIL fill_final got full=%b lvl=%0d wptr=%b required full=1 lvl=16 wptr=11000", wfull, wlevel, wptr);
      end
   endtask

   task automatic test_overflow();
      logic [A:0] held;
      held = wptr;
      set_in(1'b1, 1'b0, '0);
      #1;
      checks++;
      if (wen !== 1'b0) begin
         failures++;
         $display("FAIL ovf_wen got=%b required=0", wen);
      end
      tick();
      checks++;
      if (wptr !== held || woverflow !== 1'b1 || woverflow !== e.wovf) begin
         failures++;
         $display("FAIL ovf_set got wptr=%b wovf=%b required wptr=%b wovf=1", wptr, woverflow, held);
      end
      set_in(1'b1, 1'b1, '0);
      tick();
      checks++;
      if (woverflow !== 1'b1 || woverflow !== e.wovf) begin
         failures++;
         $display("FAIL ovf_set_priority got=%b required=1", woverflow);
      end
      set_in(1'b0, 1'b1, '0);
      tick();
      checks++;
      if (woverflow !== 1'b0 || woverflow !== e.wovf) begin
         failures++;
         $display("FAIL ovf_clear got=%b required=0", woverflow);
      end
      $display("test_overflow done wovf=%b", woverflow);
   endtask

   task automatic test_read_advance();
      set_in(1'b0, 1'b0, 5'b00001);
      tick();
      checks++;
      if (wfull !== 1'b0 || wlevel !== 5'd15 || walmost_full !== 1'b1 || wlevel !== e.wlevel) begin
         failures++;
         $display("FAIL rd_adv_unfull got full=%b lvl=%0d af=%b required full=0 lvl=15 af=1", wfull, wlevel, walmost_full);
      end
      set_in(1'b1, 1'b0, 5'b00001);
      tick();
      checks++;
      if (wfull !== 1'b1 || wptr !== 5'b11001 || wptr !== e.wptr) begin
         failures++;
         $display("FAIL rd_adv_refill got full=%b wptr=%b required full=1 wptr=11001", wfull, wptr);
      end
      $display("test_read_advance done wptr=%b", wptr);
   endtask

   task automatic test_async_reset();
      wrst = 1'b1;
      #2;
      wrst = 1'b0;
      model_reset();
      for (int i = 0; i < 10; i++) begin
         set_in(1'b1, 1'b0, '0);
         tick();
      end
      checks++;
      if (wlevel !== 5'd10 || wlevel !== e.wlevel) begin
         failures++;
         $display("FAIL arst_prefill got lvl=%0d required=10", wlevel);
      end
      #1;
      wrst = 1'b1;
      #1;
      checks++;
      if ({wptr, waddr, wfull, walmost_full, wlevel, woverflow, wen} !== '0) begin
         failures++;
         $display("FAIL arst_immediate got wptr=%b waddr=%0d lvl=%0d wen=%b required all 0", wptr, waddr, wlevel, wen);
      end
      #1;
      wrst = 1'b0;
      model_reset();
      set_in(1'b1, 1'b0, '0);
      tick();
      checks++;
      if (wptr !== 5'b00001 || waddr !== 4'd1 || wptr !== e.wptr) begin
         failures++;
         $display("FAIL arst_resume got wptr=%b waddr=%0d required wptr=00001 waddr=1", wptr, waddr);
      end
      $display("test_async_reset done wptr=%b", wptr);
   endtask

   task automatic test_wrap();
      logic [A:0]   prev_ptr;
      logic [A-1:0] prev_addr;
      int wraps;
      int toggles;
      wrst = 1'b1;
      #2;
      wrst = 1'b0;
      model_reset();
      prev_ptr = wptr;
      prev_addr = waddr;
      wraps = 0;
      toggles = 0;
      for (int k = 1; k <= 40; k++) begin
         set_in(1'b1, 1'b0, gray(m_wbin - 5'd8));
         tick();
         checks++;
         if (wfull !== 1'b0 || !(wlevel == 5'd8 || wlevel == 5'd9) || wlevel !== e.wlevel || waddr !== e.waddr) begin
            failures++;
            $display("FAIL wrap_level k=%0d got full=%b lvl=%0d waddr=%0d required full=0 lvl=%0d waddr=%0d",
                     k, wfull, wlevel, waddr, e.wlevel, e.waddr);
         end
         checks++;
         if ($countones(wptr ^ prev_ptr) != 1) begin
            failures++;
            $display("FAIL wrap_hamming k=%0d got prev=%b now=%b required distance 1", k, prev_ptr, wptr);
         end
         checks++;
         if ((wptr[A] != prev_ptr[A]) !== (k == 16 || k == 32)) begin
            failures++;
            $display("FAIL wrap_msb k=%0d got toggle=%b required=%b", k, (wptr[A] != prev_ptr[A]), (k == 16 || k == 32));
         end
         if (wptr[A] != prev_ptr[A]) toggles++;
         if (prev_addr == 4'd15 && waddr == 4'd0) wraps++;
         prev_ptr = wptr;
         prev_addr = waddr;
      end
      checks++;
      if (wraps != 2 || toggles != 2) begin
         failures++;
         $display("FAIL wrap_count got wraps=%0d toggles=%0d required wraps=2 toggles=2", wraps, toggles);
      end
      $display("test_wrap done wraps=%0d toggles=%0d", wraps, toggles);
   endtask

   initial begin
      model_reset();
      #7;
      test_reset();
      test_fill();
      test_overflow();
      test_read_advance();
      test_async_reset();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got timeout required completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/afifo_wptr_full.md
Name: afifo_wptr_full

Overview:
Write-side pointer and status controller of the asynchronous FIFO, in the wclk domain.
- Inputs: write requests, plus the read pointer already synchronized into wclk.
- Maintains the binary write address for the dual-port RAM.
- Publishes the Gray-coded write pointer to the write-to-read synchronizer.
- Generates full, almost-full, fill level and a sticky overflow flag.

Parameters:
ADDRSIZE, 4, RAM address width; FIFO depth = 2^ADDRSIZE; pointers are ADDRSIZE+1 bits.
AFULL_THRESH, 14, fill level (entries) at or above which walmost_full asserts; legal range 1..2^ADDRSIZE.

Ports:
wclk  input  1  write-domain clock.
wrst  input  1  reset; asynchronous, active-high.
winc  input  1  write request for this cycle.
woverflow_clr  input  1  clears the sticky overflow flag.
rptr_wclk  input  ADDRSIZE+1  Gray read pointer, already 2-flop synchronized into wclk.
wen  output  1  RAM write enable (combinational).
waddr  output  ADDRSIZE  RAM write address = wbin[ADDRSIZE-1:0].
wptr  output  ADDRSIZE+1  registered Gray write pointer, sent to the w2r synchronizer.
wfull  output  1  registered full flag.
walmost_full  output  1  registered almost-full flag.
wlevel  output  ADDRSIZE+1  registered fill estimate, 0..2^ADDRSIZE.
woverflow  output  1  sticky: a write was attempted while full.

Behaviour:
- Reset (async, while wrst=1): wbin=0, wptr=0, wfull=0, walmost_full=0, wlevel=0, woverflow=0. Consequently waddr=0 and wen=0.
- Internal state: wbin, the (ADDRSIZE+1)-bit binary write counter.
- Accept: wen = winc & ~wfull. Writes while full are dropped and leave the pointers unchanged.
- Next-state values, all registered on the rising edge of wclk:
  - wbinnext = wbin + wen, wrapping modulo 2^(ADDRSIZE+1).
  - wgraynext = (wbinnext >> 1) ^ wbinnext.
  - wptr <= wgraynext, so wptr changes by exactly one bit per accepted write.
- Full:
  - wfull <= (wgraynext == {~rptr_wclk[A:A-1], rptr_wclk[A-2:0]}), where A = ADDRSIZE.
  - It asserts on the same edge that accepts the write filling the last entry.
  - It deasserts one edge after rptr_wclk advances.
- Level:
  - rbin = Gray-to-binary of rptr_wclk (XOR-prefix from the MSB down).
  - wlevel <= (wbinnext - rbin) mod 2^(ADDRSIZE+1).
  - The value is pessimistic because rptr_wclk is stale by the synchronizer delay. It never under-reports fill.
- Almost full: walmost_full <= (level_next >= AFULL_THRESH), using the same level_next value as wlevel.
- Overflow:
  - If winc & wfull: woverflow <= 1.
  - Else if woverflow_clr: woverflow <= 0.
  - Set takes priority when set and clear occur in the same cycle.
- Latency: a write accepted in cycle N is visible on wptr, wfull, wlevel and walmost_full after edge N. No combinational path exists from winc to any registered output. wen is the only combinational output.
- Wrap-around: the MSB of wbin toggles every 2^ADDRSIZE writes. waddr wraps from 2^ADDRSIZE-1 to 0.
- Simultaneous write and read-pointer advance in the same cycle: both are folded into next-state in that cycle, so full and level stay consistent.
- Reset mid-operation: all outputs clear immediately, independent of wclk. Normal operation resumes on the first edge after wrst falls.
- rptr_wclk is assumed to be a valid Gray value that changes by at most 1 bit per edge. Behaviour under any other input is unspecified.

Test Plan:
All scenarios use ADDRSIZE=4, AFULL_THRESH=14.
1. Assert wrst with winc=1 and wclk running → wptr=0, waddr=0, wfull=0, wlevel=0, woverflow=0, wen=0 throughout reset.
2. rptr_wclk=0, 16 back-to-back winc →
   - waddr steps 0..15.
   - walmost_full=1 after the 14th edge.
   - After the 16th edge: wfull=1, wlevel=16, wptr=5'b11000 (Gray of 16).
3. While full, pulse winc for 1 cycle → wen=0, wptr unchanged, woverflow=1. Then pulse woverflow_clr with winc=1 → woverflow stays 1 (set priority). Then pulse woverflow_clr with winc=0 → woverflow=0.
4. From full, set rptr_wclk=5'b00001 (Gray of 1) →
   - Next edge: wfull=0, wlevel=15, walmost_full=1.
   - One further write: wfull=1 again, wptr=5'b11001 (Gray of 17).
5. 40 writes with rptr_wclk tracking Gray(wbin-8) →
   - wfull never asserts; wlevel stays 8 or 9.
   - Each wptr step has Hamming distance 1.
   - waddr wraps 15→0 twice; MSB of wbin toggles at the 16th and 32nd writes.
6. Assert wrst asynchronously between clock edges at fill 10 → outputs drop to 0 before the next edge. After release, one write gives wptr=5'b00001 and waddr=1.
